// File: rtl/clk_div_ctrl.sv
// Run-time controller for a glitch-free divide-by-2*div clock divider with handshake reconfiguration.
// Optional CLK_DIV_CTRL_CNT_EN adds a 16-bit period_cnt output counting clk_out periods.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             err
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic             xfer;
  logic             xfer_ok;
  logic             wrap;
  logic             fall;
  logic             div_load;
  logic [CNT_W-1:0] cnt_step;

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0]      period_cnt_q, period_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    busy_d      = busy_q;
    div_load    = 1'b0;

    xfer        = cfg_valid & cfg_ready_q;
    xfer_ok     = xfer & (cfg_div != '0);
    err_d       = xfer & (cfg_div == '0);
    wrap        = (cnt_q == (div_q - 1'b1));
    fall        = wrap & clk_out_q;
    cnt_step    = wrap ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (xfer_ok) begin
          div_d    = cfg_div;
          div_load = 1'b1;
        end
        if (en) state_d = S_RUN;
      end

      S_RUN, S_PEND: begin
        // Stopping from the low phase holds clk_out low so no rise can slip out.
        if (!en && !clk_out_q) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_step;
          if (wrap) begin
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
          end
          if (!en) begin
            state_d = S_STOP;
          end else if (state_q == S_PEND && fall) begin
            div_d    = pend_q;
            busy_d   = 1'b0;
            div_load = 1'b1;
            state_d  = S_RUN;
          end
        end
        if (state_q == S_RUN && xfer_ok) begin
          pend_d = cfg_div;
          busy_d = 1'b1;
          if (en) state_d = S_PEND;
        end
      end

      S_STOP: begin
        if (clk_out_q) begin
          cnt_d = cnt_step;
          if (wrap) clk_out_d = 1'b0;
        end
        // A ratio offered on the cycle of IDLE entry supersedes the one already pending.
        if (!clk_out_q || wrap) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          if (xfer_ok) begin
            div_d    = cfg_div;
            div_load = 1'b1;
          end else if (busy_q) begin
            div_d    = pend_q;
            div_load = 1'b1;
          end
        end else if (xfer_ok) begin
          pend_d = cfg_div;
          busy_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    cfg_ready_d = (state_d != S_PEND);
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (div_load) period_cnt_d = '0;
    else if (tick_d) period_cnt_d = period_cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= CNT_W'(DEFAULT_DIV);
      cnt_q       <= '0;
      pend_q      <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n) period_cnt_q <= '0;
    else        period_cnt_q <= period_cnt_d;
  end

  assign period_cnt = period_cnt_q;
`endif

  assign cfg_ready = cfg_ready_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
